// File: rtl/modbus_hreg_pkg.sv
// modbus_hreg_pkg: shared encodings for the Modbus holding-register arbiter
package modbus_hreg_pkg;
   localparam int REG_W = 16;
   localparam logic ST_OK = 1'b0;
   localparam logic ST_REJ = 1'b1;
   typedef enum logic [1:0] {IDLE, WR_MB, WR_HOST} state_t;
   typedef enum logic {GNT_MB, GNT_HOST} gnt_t;
endpackage

// File: rtl/hreg_irq_stretch.sv
// hreg_irq_stretch: reloadable down-counter stretching a one-cycle trigger to INTR_CLOCK cycles
module hreg_irq_stretch #(
   parameter int INTR_CLOCK = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trig,
   output logic pulse
);
   localparam int CW = $clog2(INTR_CLOCK + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk)
      if (!rst_n) cnt <= '0;
      else if (trig) cnt <= CW'(INTR_CLOCK);
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign pulse = cnt != '0;
endmodule

// File: rtl/modbus_hreg_arbiter.sv
// modbus_hreg_arbiter: Modbus/host write arbiter over holding registers; MODBUS_HREG_OVR_CNT_EN adds mb_ovr_cnt
module modbus_hreg_arbiter
   import modbus_hreg_pkg::*;
#(
   parameter int REG_NUM = 4,
   parameter int INTR_CLOCK = 5,
   parameter logic [REG_W-1:0] RST_VAL = 16'h0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mb_wen,
   input  logic [7:0]               mb_waddr,
   input  logic [REG_W-1:0]         mb_wdat,
   output logic                     mb_w_done,
   output logic                     mb_w_status,
   input  logic                     host_wreq,
   input  logic [7:0]               host_waddr,
   input  logic [REG_W-1:0]         host_wdat,
   output logic                     host_wack,
   output logic                     host_werr,
   input  logic [REG_NUM-1:0]       wr_protect,
   output logic [REG_W*REG_NUM-1:0] reg_bank_o,
   output logic [REG_NUM-1:0]       reg_update,
   output logic                     busy
`ifdef MODBUS_HREG_OVR_CNT_EN
   ,
   output logic [7:0]               mb_ovr_cnt
`endif
);
   state_t state, state_nx;
   gnt_t last_grant, last_nx;
   logic mb_pend, mb_cap, host_vld, pick_mb;
   logic [7:0] mb_addr_q;
   logic [REG_W-1:0] mb_dat_q;
   logic [REG_NUM-1:0] mb_hit, host_hit;
   assign host_vld = host_wreq && !host_wack;
   assign mb_cap = mb_wen && !mb_pend && state != WR_MB;
   assign busy = state != IDLE || mb_pend;
   always_comb begin
      pick_mb = mb_pend && (!host_vld || last_grant == GNT_HOST);
      state_nx = state != IDLE ? IDLE : pick_mb ? WR_MB : host_vld ? WR_HOST : IDLE;
      last_nx = (state == IDLE && mb_pend && host_vld) ? (pick_mb ? GNT_MB : GNT_HOST) : last_grant;
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= IDLE;
         last_grant <= GNT_HOST;
         mb_pend <= 1'b0;
         mb_addr_q <= '0;
         mb_dat_q <= '0;
         mb_w_done <= 1'b0;
         mb_w_status <= ST_OK;
         host_wack <= 1'b0;
         host_werr <= 1'b0;
      end else begin
         state <= state_nx;
         last_grant <= last_nx;
         if (mb_cap) begin
            mb_pend <= 1'b1;
            mb_addr_q <= mb_waddr;
            mb_dat_q <= mb_wdat;
         end else if (state_nx == WR_MB) mb_pend <= 1'b0;
         mb_w_done <= state == WR_MB;
         mb_w_status <= (state == WR_MB && mb_hit == '0) ? ST_REJ : ST_OK;
         host_wack <= state == WR_HOST;
         host_werr <= state == WR_HOST && host_hit == '0;
      end
   // full 8-bit address compare per register; a miss on every register is a reject
   for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
      logic [REG_W-1:0] r;
      assign mb_hit[i] = state == WR_MB && mb_addr_q == 8'(i) && !wr_protect[i];
      assign host_hit[i] = state == WR_HOST && host_waddr == 8'(i);
      always_ff @(posedge clk)
         if (!rst_n) r <= RST_VAL;
         else if (mb_hit[i]) r <= mb_dat_q;
         else if (host_hit[i]) r <= host_wdat;
      assign reg_bank_o[REG_W*i +: REG_W] = r;
      hreg_irq_stretch #(.INTR_CLOCK(INTR_CLOCK)) u_irq (
         .clk(clk),
         .rst_n(rst_n),
         .trig(mb_hit[i]),
         .pulse(reg_update[i])
      );
   end
`ifdef MODBUS_HREG_OVR_CNT_EN
   always_ff @(posedge clk)
      if (!rst_n) mb_ovr_cnt <= '0;
      else if (mb_wen && !mb_cap && mb_ovr_cnt != 8'hFF) mb_ovr_cnt <= mb_ovr_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_modbus_hreg_arbiter.sv
// tb_modbus_hreg_arbiter: directed vector table plus hand sequences for contention, retrigger and reset
module tb_modbus_hreg_arbiter;
   logic clk = 0, rst_n = 0, mb_wen = 0, host_wreq = 0;
   logic [7:0] mb_waddr = 0, host_waddr = 0;
   logic [15:0] mb_wdat = 0, host_wdat = 0;
   logic [3:0] wr_protect = 0;
   logic mb_w_done, mb_w_status, host_wack, host_werr, busy;
   logic [63:0] reg_bank_o;
   logic [3:0] reg_update;
`ifdef MODBUS_HREG_OVR_CNT_EN
   logic [7:0] mb_ovr_cnt;
`endif
   int checks = 0, errors = 0;

   typedef struct {
      logic host;
      logic [7:0] addr;
      logic [15:0] dat;
      logic [3:0] prot;
      logic exp_err;
      int exp_lat;
      logic [63:0] exp_bank;
      logic [3:0] exp_upd;
   } vec_t;
   vec_t vecs[9];

   always #5 clk = ~clk;

   modbus_hreg_arbiter #(.REG_NUM(4), .INTR_CLOCK(5), .RST_VAL(16'h0000)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mb_wen(mb_wen),
      .mb_waddr(mb_waddr),
      .mb_wdat(mb_wdat),
      .mb_w_done(mb_w_done),
      .mb_w_status(mb_w_status),
      .host_wreq(host_wreq),
      .host_waddr(host_waddr),
      .host_wdat(host_wdat),
      .host_wack(host_wack),
      .host_werr(host_werr),
      .wr_protect(wr_protect),
      .reg_bank_o(reg_bank_o),
      .reg_update(reg_update),
      .busy(busy)
`ifdef MODBUS_HREG_OVR_CNT_EN
      ,
      .mb_ovr_cnt(mb_ovr_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      mb_wen = 0;
      host_wreq = 0;
      wr_protect = 0;
      rst_n = 0;
      repeat (2) tick();
      rst_n = 1;
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int lat, n;
      logic got;
      wr_protect = v.prot;
      if (v.host) begin
         host_wreq = 1;
         host_waddr = v.addr;
         host_wdat = v.dat;
      end else begin
         mb_wen = 1;
         mb_waddr = v.addr;
         mb_wdat = v.dat;
      end
      lat = 0;
      got = 0;
      while (!got && lat < 10) begin
         tick();
         lat++;
         mb_wen = 0;
         got = v.host ? host_wack : mb_w_done;
      end
      chk($sformatf("v%0d_latency", k), 64'(lat), 64'(v.exp_lat));
      chk($sformatf("v%0d_err", k), {63'b0, v.host ? host_werr : mb_w_status}, {63'b0, v.exp_err});
      chk($sformatf("v%0d_bank", k), reg_bank_o, v.exp_bank);
      chk($sformatf("v%0d_update", k), {60'b0, reg_update}, {60'b0, v.exp_upd});
      if (v.host) begin
         tick();
         host_wreq = 0;
         chk($sformatf("v%0d_no_regrant_busy", k), {63'b0, busy}, 64'd0);
         tick();
         chk($sformatf("v%0d_no_second_ack", k), {63'b0, host_wack}, 64'd0);
      end else begin
         n = 0;
         while (reg_update != 0 && n < 20) begin
            n++;
            tick();
         end
         chk($sformatf("v%0d_update_len", k), 64'(n), (v.exp_upd != 0) ? 64'd5 : 64'd0);
      end
      repeat (2) tick();
   endtask

   // hc: cycle at which host_wreq rises relative to the Modbus strobe
   task automatic race(input int hc, input logic [7:0] a, input logic [15:0] md, input logic [15:0] hd,
                       output int dc, output int ac);
      dc = -1;
      ac = -1;
      mb_wen = 1;
      mb_waddr = a;
      mb_wdat = md;
      host_waddr = a;
      host_wdat = hd;
      if (hc == 0) host_wreq = 1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         mb_wen = 0;
         if (c == hc) host_wreq = 1;
         if (ac >= 0 && c == ac + 1) host_wreq = 0;
         if (mb_w_done) dc = c;
         if (host_wack) ac = c;
      end
      host_wreq = 0;
   endtask

   initial begin
      int dc, ac, n, lat;
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int dc, ac, n, lat;
      vecs[0] = '{1'b0, 8'h01, 16'hBEEF, 4'h0, 1'b0, 3, 64'h0000_0000_BEEF_0000, 4'b0010};
      vecs[1] = '{1'b1, 8'h02, 16'h1234, 4'h0, 1'b0, 2, 64'h0000_1234_BEEF_0000, 4'b0000};
      vecs[2] = '{1'b0, 8'h00, 16'h1111, 4'h1, 1'b1, 3, 64'h0000_1234_BEEF_0000, 4'b0000};
      vecs[3] = '{1'b0, 8'h07, 16'h2222, 4'h0, 1'b1, 3, 64'h0000_1234_BEEF_0000, 4'b0000};
      vecs[4] = '{1'b0, 8'h41, 16'h3333, 4'h0, 1'b1, 3, 64'h0000_1234_BEEF_0000, 4'b0000};
      vecs[5] = '{1'b1, 8'h00, 16'h9999, 4'h1, 1'b0, 2, 64'h0000_1234_BEEF_9999, 4'b0000};
      vecs[6] = '{1'b1, 8'h04, 16'h7777, 4'h0, 1'b1, 2, 64'h0000_1234_BEEF_9999, 4'b0000};
      vecs[7] = '{1'b1, 8'h83, 16'h8888, 4'h0, 1'b1, 2, 64'h0000_1234_BEEF_9999, 4'b0000};
      vecs[8] = '{1'b0, 8'h03, 16'hCAFE, 4'h7, 1'b0, 3, 64'hCAFE_1234_BEEF_9999, 4'b1000};

      rst_n = 0;
      repeat (3) tick();
      chk("reset_bank", reg_bank_o, 64'd0);
      chk("reset_update", {60'b0, reg_update}, 64'd0);
      chk("reset_done", {63'b0, mb_w_done}, 64'd0);
      chk("reset_ack", {63'b0, host_wack}, 64'd0);
      chk("reset_busy", {63'b0, busy}, 64'd0);
      rst_n = 1;
      tick();

      for (int k = 0; k < 9; k++) run_vec(vecs[k], k);
      wr_protect = 0;

      // simultaneous start from reset: Modbus not yet pending, so host goes first
      do_reset();
      race(0, 8'h00, 16'hAAAA, 16'h5555, dc, ac);
      chk("race_ack_cycle", 64'(ac), 64'd2);
      chk("race_done_cycle", 64'(dc), 64'd4);
      chk("race_r0", {48'b0, reg_bank_o[15:0]}, 64'h0000_0000_0000_AAAA);

      // true ties alternate, starting with Modbus after reset
      race(1, 8'h01, 16'h0101, 16'h0202, dc, ac);
      chk("tie1_done_cycle", 64'(dc), 64'd3);
      chk("tie1_ack_cycle", 64'(ac), 64'd5);
      chk("tie1_r1", {48'b0, reg_bank_o[31:16]}, 64'h0202);
      race(1, 8'h01, 16'h0303, 16'h0404, dc, ac);
      chk("tie2_ack_cycle", 64'(ac), 64'd3);
      chk("tie2_done_cycle", 64'(dc), 64'd5);
      chk("tie2_r1", {48'b0, reg_bank_o[31:16]}, 64'h0303);
      repeat (8) tick();

      // second strobe while pending is dropped
      mb_wen = 1;
      mb_waddr = 8'h03;
      mb_wdat = 16'h1111;
      tick();
      mb_wdat = 16'h2222;
      tick();
      mb_wen = 0;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (mb_w_done) n++;
      end
      chk("ignore_done_count", 64'(n), 64'd1);
      chk("ignore_r3", {48'b0, reg_bank_o[63:48]}, 64'h1111);
`ifdef MODBUS_HREG_OVR_CNT_EN
      chk("ignore_ovr_cnt", {56'b0, mb_ovr_cnt}, 64'd1);
`endif
      repeat (6) tick();

      // retrigger issued in the done cycle lands on update cycle 4
      mb_wen = 1;
      mb_waddr = 8'h01;
      mb_wdat = 16'hAB01;
      lat = 0;
      while (!mb_w_done && lat < 10) begin
         tick();
         lat++;
         mb_wen = 0;
      end
      chk("retrig_latency", 64'(lat), 64'd3);
      mb_wen = 1;
      mb_wdat = 16'hAB02;
      n = 0;
      while (reg_update[1] && n < 30) begin
         n++;
         tick();
         mb_wen = 0;
      end
      mb_wen = 0;
      chk("retrig_len", 64'(n), 64'd8);
      chk("retrig_r1", {48'b0, reg_bank_o[31:16]}, 64'hAB02);
      repeat (3) tick();

      // reset while in WR_MB drops the write and the done pulse
      mb_wen = 1;
      mb_waddr = 8'h02;
      mb_wdat = 16'hDDDD;
      tick();
      mb_wen = 0;
      tick();
      chk("rst_mid_busy_before", {63'b0, busy}, 64'd1);
      rst_n = 0;
      tick();
      chk("rst_mid_done", {63'b0, mb_w_done}, 64'd0);
      chk("rst_mid_bank", reg_bank_o, 64'd0);
      chk("rst_mid_busy", {63'b0, busy}, 64'd0);
      rst_n = 1;
      n = 0;
      repeat (4) begin
         tick();
         if (mb_w_done) n++;
      end
      chk("rst_mid_late_done", 64'(n), 64'd0);
      chk("rst_mid_bank_after", reg_bank_o, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/modbus_hreg_arbiter.md
Name: modbus_hreg_arbiter

Overview:
- Owns a bank of REG_NUM 16-bit Modbus holding registers (function 03/06 space).
- Arbitrates writes between two requesters: the Modbus function handler (single-cycle write strobe, done/status handshake) and a local host port (AXI-side, req/ack).
- Drives the register bank outputs and a per-register, time-stretched update interrupt for Modbus-originated writes.
- Sits between the function handler and the AXI register slice.

Parameters:
- REG_NUM, 4, number of holding registers; legal range 1..16.
- INTR_CLOCK, 5, width in clk cycles of each reg_update pulse; must be ≥1.
- RST_VAL, 16'h0000, reset value of every holding register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- mb_wen  in  1  Modbus write strobe, one-cycle pulse
- mb_waddr  in  8  Modbus register index
- mb_wdat  in  16  Modbus write data
- mb_w_done  out  1  one-cycle pulse; Modbus write finished
- mb_w_status  out  1  valid with mb_w_done; 0 = written, 1 = rejected
- host_wreq  in  1  host write request, level; held until host_wack
- host_waddr  in  8  host register index
- host_wdat  in  16  host write data
- host_wack  out  1  one-cycle pulse; host write finished
- host_werr  out  1  valid with host_wack; 1 = illegal address, no write
- wr_protect  in  REG_NUM  bit i set blocks Modbus writes to register i; host writes are never blocked
- reg_bank_o  out  16*REG_NUM  register i on bits [16i+15:16i]
- reg_update  out  REG_NUM  bit i high for INTR_CLOCK cycles after a Modbus write to register i
- busy  out  1  state≠IDLE or a Modbus request is pending

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is synchronous and active-low.
- Reset values: all registers = RST_VAL; all other outputs 0; state = IDLE; mb_pend = 0; last_grant = HOST, so Modbus wins the first tie.
- Reset mid-operation: any pending or in-flight write is dropped. No done or ack pulse is issued.
- Modbus request capture:
  - mb_wen sets mb_pend and latches mb_waddr/mb_wdat.
  - mb_wen arriving while mb_pend=1 or state=WR_MB is ignored, and the latched data is kept.
- Host request qualification: host_wreq is valid only when host_wack=0. This prevents a re-grant in the ack cycle.
- FSM states: IDLE, WR_MB, WR_HOST.
  - IDLE: if exactly one request is valid, go to its WR state. If both are valid, grant the requester ≠ last_grant, then update last_grant.
  - WR_MB / WR_HOST: commit the write (or reject it), pulse the matching done/ack for one cycle, update reg_update, and return to IDLE. The dwell is exactly one cycle.
- Modbus decode:
  - Legal only if mb_waddr < REG_NUM and wr_protect[mb_waddr] = 0.
  - Illegal: no register change; mb_w_done=1 with mb_w_status=1; reg_update unchanged.
- Host decode: host_waddr ≥ REG_NUM gives host_wack=1 with host_werr=1 and no write.
- Latency, no contention:
  - Modbus: mb_wen in cycle 0 → mb_pend in cycle 1 → WR_MB in cycle 2 → register value and mb_w_done in cycle 3.
  - Host: host_wreq in cycle 0 → WR_HOST in cycle 1 → register value and host_wack in cycle 2.
- Contention: the loser waits at most one write slot (2 cycles).
- reg_update timing:
  - A successful Modbus write to register i loads counter i to INTR_CLOCK. Bit i is high while counter ≠ 0, starting in the same cycle as mb_w_done, for exactly INTR_CLOCK cycles.
  - A retrigger while active reloads the counter (pulse extended).
  - Host writes never raise reg_update.
- Width rules: counter width is $clog2(INTR_CLOCK+1). Address compare uses the full 8 bits; upper bits are not truncated.

Optional Feature:
- Macro: MODBUS_HREG_OVR_CNT_EN.
- Defined: adds output mb_ovr_cnt[7:0]. It is an 8-bit saturating count of ignored mb_wen strobes (saturates at 8'hFF), cleared only by reset.
- Undefined: the port and the counter are absent. Dropped strobes are silent.

Decomposition:
- Package modbus_hreg_pkg:
  - FSM state encoding (IDLE, WR_MB, WR_HOST).
  - Grant encoding (GNT_MB, GNT_HOST).
  - Status constants ST_OK=1'b0, ST_REJ=1'b1.
  - REG_W=16.
- Sub-module hreg_irq_stretch: one per register, via generate. Inputs trig and INTR_CLOCK; reloadable down-counter; output pulse.

Test Plan:
1. Reset, then mb_wen with addr 1, data 16'hBEEF → mb_w_done at cycle 3 with status 0; reg_bank_o[31:16]=16'hBEEF; reg_update[1] high exactly 5 cycles.
2. host_wreq with addr 2, data 16'h1234, held → host_wack at cycle 2 with werr 0; register 2 = 16'h1234; reg_update stays 0; no second ack while req is held through the ack cycle.
3. mb_wen (addr 0, 16'hAAAA) and host_wreq (addr 0, 16'h5555) in the same cycle, from reset → host wins its slot first; Modbus write lands last, so final register 0 = 16'hAAAA. A repeated tie then grants the opposite requester.
4. wr_protect=4'b0001, mb_wen to addr 0 → done with status 1, no change, no reg_update. mb_wen to addr 7 → status 1. host write to addr 0 succeeds; host write to addr 4 → werr 1.
5. A second mb_wen while pending → ignored (ovr_cnt=1 with MODBUS_HREG_OVR_CNT_EN). Retrigger register 1 on update cycle 3 → pulse extends to 3+5 cycles. rst_n low during WR_MB → no done; all registers = RST_VAL.
